// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the three-master Wishbone arbiter: master indices,
// FSM state encoding and a one-hot to index helper.
package wb_arbiter_pkg;

   localparam int WB_NUM_MASTERS = 3;
   localparam int WB_M_FETCH     = 0;
   localparam int WB_M_LOAD      = 1;
   localparam int WB_M_STORE     = 2;

   // Pointing at the last master makes m0 the first choice after reset.
   localparam logic [1:0] WB_RR_RESET_PTR = 2'(WB_M_STORE);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

   function automatic logic [1:0] onehot_to_idx(input logic [WB_NUM_MASTERS-1:0] oh);
      logic [1:0] idx;
      idx = 2'(WB_M_FETCH);
      if (oh[WB_M_LOAD])  idx = 2'(WB_M_LOAD);
      if (oh[WB_M_STORE]) idx = 2'(WB_M_STORE);
      return idx;
   endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin selector: one-hot pick of the first requester
// strictly after the pointer, in the order m0 -> m1 -> m2 -> m0.
module wb_arbiter_rr_picker
   import wb_arbiter_pkg::*;
(
   input  logic [WB_NUM_MASTERS-1:0] i_req,
   input  logic [1:0]                i_ptr,
   output logic [WB_NUM_MASTERS-1:0] o_pick
);

   always_comb begin
      o_pick = '0;
      case (i_ptr)
         2'd0: begin
            if      (i_req[WB_M_LOAD])  o_pick[WB_M_LOAD]  = 1'b1;
            else if (i_req[WB_M_STORE]) o_pick[WB_M_STORE] = 1'b1;
            else if (i_req[WB_M_FETCH]) o_pick[WB_M_FETCH] = 1'b1;
         end
         2'd1: begin
            if      (i_req[WB_M_STORE]) o_pick[WB_M_STORE] = 1'b1;
            else if (i_req[WB_M_FETCH]) o_pick[WB_M_FETCH] = 1'b1;
            else if (i_req[WB_M_LOAD])  o_pick[WB_M_LOAD]  = 1'b1;
         end
         default: begin
            if      (i_req[WB_M_FETCH]) o_pick[WB_M_FETCH] = 1'b1;
            else if (i_req[WB_M_LOAD])  o_pick[WB_M_LOAD]  = 1'b1;
            else if (i_req[WB_M_STORE]) o_pick[WB_M_STORE] = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/wb_arbiter.sv
// Three-master to one-slave Wishbone arbiter with round-robin grant held for
// one transaction and a watchdog that errors out stalled transactions.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 16
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_m0_addr,
   input  logic [31:0] i_m1_addr,
   input  logic [31:0] i_m2_addr,
   input  logic        i_m0_cyc,
   input  logic        i_m1_cyc,
   input  logic        i_m2_cyc,
   input  logic [3:0]  i_m0_stb,
   input  logic [3:0]  i_m1_stb,
   input  logic [3:0]  i_m2_stb,
   input  logic        i_m0_we,
   input  logic        i_m1_we,
   input  logic        i_m2_we,
   input  logic [31:0] i_m0_dat,
   input  logic [31:0] i_m1_dat,
   input  logic [31:0] i_m2_dat,
   output logic [31:0] o_m_dat,
   output logic [2:0]  o_m_ack,
   output logic [2:0]  o_m_err,
   output logic [31:0] o_wb_addr,
   output logic        o_wb_cyc,
   output logic [3:0]  o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_dat,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_ack,
   input  logic        i_wb_err,
   output logic [2:0]  o_grant,
   output logic        o_timeout
);

   localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   arb_state_e                r_state,  w_state_nxt;
   logic [WB_NUM_MASTERS-1:0] r_grant,  w_grant_nxt;
   logic [1:0]                r_rr_ptr, w_rr_ptr_nxt;
   logic [TIMEOUT_W-1:0]      r_wdog,   w_wdog_nxt;

   logic [WB_NUM_MASTERS-1:0] w_req;
   logic [WB_NUM_MASTERS-1:0] w_pick;
   logic                      w_own_cyc;
   logic                      w_stall;
   logic                      w_fire;

   assign w_req = {i_m2_cyc, i_m1_cyc, i_m0_cyc};

   wb_arbiter_rr_picker u_picker (
      .i_req  (w_req),
      .i_ptr  (r_rr_ptr),
      .o_pick (w_pick)
   );

   // Slave-side mux driven only by the registered grant; all zero when idle.
   always_comb begin
      w_own_cyc = 1'b0;
      o_wb_addr = '0;
      o_wb_stb  = '0;
      o_wb_we   = 1'b0;
      o_wb_dat  = '0;
      if (r_grant[WB_M_FETCH]) begin
         w_own_cyc = i_m0_cyc;
         o_wb_addr = i_m0_addr;
         o_wb_stb  = i_m0_stb;
         o_wb_we   = i_m0_we;
         o_wb_dat  = i_m0_dat;
      end else if (r_grant[WB_M_LOAD]) begin
         w_own_cyc = i_m1_cyc;
         o_wb_addr = i_m1_addr;
         o_wb_stb  = i_m1_stb;
         o_wb_we   = i_m1_we;
         o_wb_dat  = i_m1_dat;
      end else if (r_grant[WB_M_STORE]) begin
         w_own_cyc = i_m2_cyc;
         o_wb_addr = i_m2_addr;
         o_wb_stb  = i_m2_stb;
         o_wb_we   = i_m2_we;
         o_wb_dat  = i_m2_dat;
      end
   end

   // A slave response in the limit cycle wins over the watchdog.
   assign w_stall   = (r_state == ST_OWN) && w_own_cyc && !i_wb_ack && !i_wb_err;
   assign w_fire    = w_stall && (r_wdog == WDOG_LAST);

   assign o_wb_cyc  = w_own_cyc;
   assign o_m_dat   = i_wb_dat;
   assign o_m_ack   = r_grant & {WB_NUM_MASTERS{i_wb_ack}};
   assign o_m_err   = r_grant & {WB_NUM_MASTERS{i_wb_err | w_fire}};
   assign o_grant   = r_grant;
   assign o_timeout = w_fire;

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_rr_ptr_nxt = r_rr_ptr;
      w_wdog_nxt   = r_wdog;
      case (r_state)
         ST_IDLE: begin
            if (|w_req) begin
               w_state_nxt  = ST_OWN;
               w_grant_nxt  = w_pick;
               w_rr_ptr_nxt = onehot_to_idx(w_pick);
               w_wdog_nxt   = '0;
            end
         end
         ST_OWN: begin
            if (i_wb_ack || i_wb_err || !w_own_cyc || w_fire) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
            end else begin
               w_wdog_nxt = r_wdog + TIMEOUT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= WB_RR_RESET_PTR;
         r_wdog   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_wdog   <= w_wdog_nxt;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic,
// all compared against a transaction-level reference model.
module tb_wb_arbiter;

   localparam int TO = 4;

   logic        i_clk = 1'b0;
   logic        rst;
   logic [31:0] m_addr [3];
   logic        m_cyc  [3];
   logic [3:0]  m_stb  [3];
   logic        m_we   [3];
   logic [31:0] m_dat  [3];
   logic [31:0] s_dat;
   logic        s_ack, s_err;

   logic [31:0] o_m_dat, o_wb_addr, o_wb_dat;
   logic [2:0]  o_m_ack, o_m_err, o_grant;
   logic [3:0]  o_wb_stb;
   logic        o_wb_cyc, o_wb_we, o_timeout;

   always #5 i_clk = ~i_clk;

   wb_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(16)) dut (
      .i_clk(i_clk), .i_reset(rst),
      .i_m0_addr(m_addr[0]), .i_m1_addr(m_addr[1]), .i_m2_addr(m_addr[2]),
      .i_m0_cyc(m_cyc[0]),   .i_m1_cyc(m_cyc[1]),   .i_m2_cyc(m_cyc[2]),
      .i_m0_stb(m_stb[0]),   .i_m1_stb(m_stb[1]),   .i_m2_stb(m_stb[2]),
      .i_m0_we(m_we[0]),     .i_m1_we(m_we[1]),     .i_m2_we(m_we[2]),
      .i_m0_dat(m_dat[0]),   .i_m1_dat(m_dat[1]),   .i_m2_dat(m_dat[2]),
      .o_m_dat(o_m_dat), .o_m_ack(o_m_ack), .o_m_err(o_m_err),
      .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
      .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat),
      .i_wb_dat(s_dat), .i_wb_ack(s_ack), .i_wb_err(s_err),
      .o_grant(o_grant), .o_timeout(o_timeout)
   );

   wire [111:0] obs_v = {o_grant, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat,
                         o_m_ack, o_m_err, o_timeout, o_m_dat};

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who owns the bus (-1 = nobody), last granted master,
   // and how many stalled owned cycles have elapsed.
   int           md_owner = -1;
   int           md_ptr   = 2;
   int           md_cnt   = 0;
   logic         md_fire;
   logic [111:0] exp_v;

   task automatic model_eval();
      logic [2:0]  g, ack, err;
      logic        cyc, we, to;
      logic [3:0]  stb;
      logic [31:0] addr, dat;
      g = '0; ack = '0; err = '0; cyc = 1'b0; we = 1'b0; to = 1'b0;
      stb = '0; addr = '0; dat = '0; md_fire = 1'b0;
      if (md_owner >= 0) begin
         g[md_owner] = 1'b1;
         cyc  = m_cyc[md_owner];
         stb  = m_stb[md_owner];
         we   = m_we[md_owner];
         addr = m_addr[md_owner];
         dat  = m_dat[md_owner];
         md_fire = cyc && !s_ack && !s_err && (md_cnt + 1 >= TO);
         ack[md_owner] = s_ack;
         err[md_owner] = s_err || md_fire;
         to = md_fire;
      end
      exp_v = {g, cyc, stb, we, addr, dat, ack, err, to, s_dat};
   endtask

   task automatic model_commit();
      if (rst) begin
         md_owner = -1; md_ptr = 2; md_cnt = 0;
      end else if (md_owner < 0) begin
         for (int k = 1; k <= 3; k++) begin
            int c;
            c = (md_ptr + k) % 3;
            if (m_cyc[c]) begin
               md_owner = c; md_ptr = c; md_cnt = 0;
               break;
            end
         end
      end else if (s_ack || s_err || !m_cyc[md_owner] || md_fire) begin
         md_owner = -1;
      end else begin
         md_cnt++;
      end
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 3; i++) begin
         m_cyc[i] = 1'b0; m_stb[i] = '0; m_we[i] = 1'b0;
         m_addr[i] = $urandom; m_dat[i] = $urandom;
      end
      s_ack = 1'b0; s_err = 1'b0; s_dat = $urandom;
   endtask

   task automatic set_m(input int n, input logic [3:0] stb, input logic we);
      m_cyc[n] = 1'b1; m_stb[n] = stb; m_we[n] = we;
      m_addr[n] = $urandom; m_dat[n] = $urandom;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      @(posedge i_clk); #1;
      md_owner = -1; md_ptr = 2; md_cnt = 0;
      for (int t = 0; t < 6; t++) begin
         clear_inputs();
         rst = (t < 2);
         if (t < 4) for (int i = 0; i < 3; i++) set_m(i, 4'($urandom_range(1, 15)), 1'($urandom));
         @(negedge i_clk);
         model_eval();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++; $display("FAIL reset t=%0d: got %h want %h", t, obs_v, exp_v);
         end
         if (t < 3) begin
            n_checks++;
            if (o_grant !== 3'b000 || o_wb_cyc !== 1'b0) begin
               n_errors++; $display("FAIL reset_idle t=%0d: got grant=%b cyc=%b want 000/0", t, o_grant, o_wb_cyc);
            end
         end
         if (t == 3) begin
            n_checks++;
            if (o_grant !== 3'b001) begin
               n_errors++; $display("FAIL reset_first_m0: got %b want 001", o_grant);
            end
         end
         model_commit();
         @(posedge i_clk); #1;
      end
   endtask

   task automatic test_single_load();
      for (int t = 0; t < 6; t++) begin
         clear_inputs();
         if (t < 4) set_m(1, 4'b0100, 1'b0);
         if (t == 3) begin s_ack = 1'b1; s_dat = 32'h11223344; end
         @(negedge i_clk);
         model_eval();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++; $display("FAIL single_load t=%0d: got %h want %h", t, obs_v, exp_v);
         end
         if (t == 1) begin
            n_checks++;
            if (o_grant !== 3'b010 || o_wb_stb !== 4'b0100) begin
               n_errors++; $display("FAIL load_grant: got grant=%b stb=%b want 010/0100", o_grant, o_wb_stb);
            end
         end
         if (t == 3) begin
            n_checks++;
            if (o_m_ack !== 3'b010 || o_m_dat !== 32'h11223344) begin
               n_errors++; $display("FAIL load_ack: got ack=%b dat=%h want 010/11223344", o_m_ack, o_m_dat);
            end
         end
         if (t == 4) begin
            n_checks++;
            if (o_grant !== 3'b000) begin
               n_errors++; $display("FAIL load_idle: got %b want 000", o_grant);
            end
         end
         model_commit();
         @(posedge i_clk); #1;
      end
   endtask

   task automatic test_contention();
      logic [2:0] grants[$];
      int         gaps[$];
      logic [2:0] prev;
      int         idle_run;
      logic [2:0] want [4];
      want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b001;
      prev = '0; idle_run = 0;
      for (int t = 0; t < 15; t++) begin
         clear_inputs();
         rst = (t == 0);
         if (t >= 1 && t <= 12) for (int i = 0; i < 3; i++) set_m(i, 4'b1111, 1'b0);
         s_ack = (md_owner >= 0 && md_cnt >= 1);
         @(negedge i_clk);
         model_eval();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++; $display("FAIL contention t=%0d: got %h want %h", t, obs_v, exp_v);
         end
         if (t >= 1) begin
            if (o_grant != 3'b000 && prev == 3'b000) begin
               if (grants.size() > 0) gaps.push_back(idle_run);
               grants.push_back(o_grant);
            end
            idle_run = (o_grant == 3'b000) ? idle_run + 1 : 0;
            prev = o_grant;
         end
         model_commit();
         @(posedge i_clk); #1;
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= grants.size()) begin
            n_errors++; $display("FAIL contention_order[%0d]: got none want %b", i, want[i]);
         end else if (grants[i] !== want[i]) begin
            n_errors++; $display("FAIL contention_order[%0d]: got %b want %b", i, grants[i], want[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= gaps.size()) begin
            n_errors++; $display("FAIL contention_gap[%0d]: got none want 1", i);
         end else if (gaps[i] != 1) begin
            n_errors++; $display("FAIL contention_gap[%0d]: got %0d want 1", i, gaps[i]);
         end
      end
   endtask

   task automatic test_timeout(input logic ack_at_limit);
      int n;
      n = ack_at_limit ? 1 : 2;
      for (int t = 0; t < 7; t++) begin
         clear_inputs();
         if (t <= 4) set_m(n, 4'($urandom_range(1, 15)), !ack_at_limit);
         if (ack_at_limit && t == 4) s_ack = 1'b1;
         @(negedge i_clk);
         model_eval();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++; $display("FAIL timeout%0d t=%0d: got %h want %h", ack_at_limit, t, obs_v, exp_v);
         end
         if (t >= 1 && t <= 3) begin
            n_checks++;
            if (o_timeout !== 1'b0 || o_m_err !== 3'b000) begin
               n_errors++; $display("FAIL timeout_early t=%0d: got to=%b err=%b want 0/000", t, o_timeout, o_m_err);
            end
         end
         if (t == 4 && !ack_at_limit) begin
            n_checks++;
            if (o_timeout !== 1'b1 || o_m_err !== 3'b100) begin
               n_errors++; $display("FAIL timeout_fire: got to=%b err=%b want 1/100", o_timeout, o_m_err);
            end
         end
         if (t == 4 && ack_at_limit) begin
            n_checks++;
            if (o_timeout !== 1'b0 || o_m_err !== 3'b000 || o_m_ack !== 3'b010) begin
               n_errors++; $display("FAIL ack_at_limit: got to=%b err=%b ack=%b want 0/000/010", o_timeout, o_m_err, o_m_ack);
            end
         end
         if (t == 5) begin
            n_checks++;
            if (o_grant !== 3'b000) begin
               n_errors++; $display("FAIL timeout_idle%0d: got %b want 000", ack_at_limit, o_grant);
            end
         end
         model_commit();
         @(posedge i_clk); #1;
      end
   endtask

   task automatic test_abort();
      for (int t = 0; t < 5; t++) begin
         clear_inputs();
         if (t <= 1) set_m(0, 4'b0011, 1'b0);
         if (t == 3) s_ack = 1'b1;
         @(negedge i_clk);
         model_eval();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++; $display("FAIL abort t=%0d: got %h want %h", t, obs_v, exp_v);
         end
         if (t == 2) begin
            n_checks++;
            if (o_wb_cyc !== 1'b0 || o_m_ack !== 3'b000) begin
               n_errors++; $display("FAIL abort_drop: got cyc=%b ack=%b want 0/000", o_wb_cyc, o_m_ack);
            end
         end
         if (t == 3) begin
            n_checks++;
            if (o_m_ack !== 3'b000 || o_grant !== 3'b000) begin
               n_errors++; $display("FAIL abort_late_ack: got ack=%b grant=%b want 000/000", o_m_ack, o_grant);
            end
         end
         model_commit();
         @(posedge i_clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      for (int t = 0; t < 7; t++) begin
         clear_inputs();
         rst = (t == 2);
         if (t <= 1) set_m(1, 4'b1000, 1'b1);
         if (t >= 2 && t <= 4) for (int i = 0; i < 3; i++) set_m(i, 4'b1111, 1'b0);
         @(negedge i_clk);
         model_eval();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++; $display("FAIL reset_mid t=%0d: got %h want %h", t, obs_v, exp_v);
         end
         if (t == 3) begin
            n_checks++;
            if (o_wb_cyc !== 1'b0 || o_grant !== 3'b000) begin
               n_errors++; $display("FAIL reset_mid_idle: got cyc=%b grant=%b want 0/000", o_wb_cyc, o_grant);
            end
         end
         if (t == 4) begin
            n_checks++;
            if (o_grant !== 3'b001) begin
               n_errors++; $display("FAIL reset_mid_m0: got %b want 001", o_grant);
            end
         end
         model_commit();
         @(posedge i_clk); #1;
      end
      rst = 1'b0;
   endtask

   task automatic test_random();
      for (int t = 0; t < 800; t++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 3; i++) begin
            m_cyc[i]  = ($urandom_range(0, 9) < 7);
            m_stb[i]  = 4'($urandom);
            m_we[i]   = 1'($urandom);
            m_addr[i] = $urandom;
            m_dat[i]  = $urandom;
         end
         s_ack = ($urandom_range(0, 9) < 2);
         s_err = ($urandom_range(0, 19) == 0);
         s_dat = $urandom;
         @(negedge i_clk);
         model_eval();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_errors++; $display("FAIL random t=%0d: got %h want %h", t, obs_v, exp_v);
         end
         model_commit();
         @(posedge i_clk); #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_contention();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_abort();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
